// File: rtl/contour_pkg.sv
// Shared constants, algorithm codes and scheduler state encoding for the contour mesh scheduler.
package contour_pkg;

  localparam logic [1:0] ALGO_PIXEL  = 2'b00;
  localparam logic [1:0] ALGO_RDBF   = 2'b01;
  localparam logic [1:0] ALGO_VERTEX = 2'b10;

  localparam int unsigned MESH_W       = 26;
  localparam int unsigned MESH_H       = 18;
  localparam int unsigned CONTOUR_BITS = MESH_W * MESH_H;
  localparam int unsigned FRAME_BITS   = 2 * CONTOUR_BITS;
  localparam int unsigned CNT_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESULT
  } state_t;

  // The unused code 11 falls back to pixel-following.
  function automatic logic [1:0] legal_algo(input logic [1:0] code);
    return (code == 2'b11) ? ALGO_PIXEL : code;
  endfunction

endpackage

// File: rtl/contour_run_timer.sv
// Down-counter timing the enabled mesh cycles of one contour run; saturates at zero.
module contour_run_timer
  import contour_pkg::*;
#(
  parameter int unsigned RUN_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tc_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(RUN_CYCLES);
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Terminal count marks the last enabled cycle of the run.
  assign tc_c = enable && (count == CNT_W'(1));

endmodule

// File: rtl/contour_sched.sv
// Frame scheduler for the contour mesh: accepts a frame, presets and runs the mesh, captures the contour.
module contour_sched
  import contour_pkg::*;
#(
  parameter int unsigned RUN_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FRAME_BITS-1:0]   frame_in,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [1:0]              algo_req,
  input  logic                    sweep,
  output logic [FRAME_BITS-1:0]   mesh_inp,
  output logic                    mesh_high,
  output logic [1:0]              mesh_algo,
  input  logic [CONTOUR_BITS-1:0] mesh_contour,
  output logic [CONTOUR_BITS-1:0] res_contour,
  output logic [1:0]              res_algo,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy
);

  state_t state;
  logic   ready_q;
  logic   sweep_q;
  logic   run_done_c;

  contour_run_timer #(.RUN_CYCLES(RUN_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_LOAD),
    .enable (state == ST_RUN),
    .tc_c   (run_done_c)
  );

  // Gated by rst so the scheduler never advertises readiness during reset.
  assign frame_ready = ready_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      sweep_q     <= 1'b0;
      mesh_high   <= 1'b0;
      mesh_inp    <= '0;
      mesh_algo   <= ALGO_PIXEL;
      res_contour <= '0;
      res_algo    <= ALGO_PIXEL;
      res_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_valid && ready_q) begin
            mesh_inp  <= frame_in;
            mesh_algo <= sweep ? ALGO_PIXEL : legal_algo(algo_req);
            sweep_q   <= sweep;
            ready_q   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mesh_high <= 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (run_done_c) begin
            res_contour <= mesh_contour;
            res_algo    <= mesh_algo;
            res_valid   <= 1'b1;
            mesh_high   <= 1'b0;
            state       <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            // A sweep steps through the algorithms on the same latched frame.
            if (sweep_q && (res_algo != ALGO_VERTEX)) begin
              mesh_algo <= 2'(res_algo + 2'd1);
              state     <= ST_LOAD;
            end else begin
              ready_q <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
